// File: rtl/inst_fetch.sv
// Instruction fetch front end: owns the fetch PC, keeps one read outstanding on
// the SRAM-style port and buffers {pc, inst} pairs for decode in a 2-entry queue.
module inst_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h1c00_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  inst_req,
  output logic [ADDR_WIDTH-1:0] inst_addr,
  input  logic                  inst_addr_ok,
  input  logic [INST_WIDTH-1:0] inst_rdata,
  input  logic                  inst_data_ok,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [INST_WIDTH-1:0] out_inst,
  input  logic                  branch_en,
  input  logic [ADDR_WIDTH-1:0] branch_addr,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr
);

  // state | meaning
  // IDLE  | no request outstanding
  // REQ   | inst_req asserted, waiting for addr_ok
  // WAIT  | address accepted, waiting for data_ok
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_nxt, addr_q, target;
  logic                  drop, drop_nxt;
  logic [ADDR_WIDTH-1:0] q_pc   [2];
  logic [INST_WIDTH-1:0] q_inst [2];
  logic                  head, tail;
  logic [1:0]            count;
  logic                  consume, redirect, data_in, push, pop, space_ok;

  assign out_valid = (count != 2'd0);
  assign out_pc    = q_pc[head];
  assign out_inst  = q_inst[head];
  assign inst_req  = (state == REQ);
  assign inst_addr = addr_q;

  assign consume  = out_valid & out_ready;
  assign redirect = consume & (branch_en | jump_en);
  assign target   = (branch_en ? branch_addr : jump_addr) & ~ADDR_WIDTH'(3);
  assign data_in  = (state == WAIT) & inst_data_ok;
  assign push     = data_in & ~drop & ~redirect;
  assign pop      = consume & ~redirect;
  assign tail     = head ^ count[0];

  // Occupancy includes the entry landing this cycle, so a newly issued read
  // always has a free slot when its data returns.
  assign space_ok = ({1'b0, count} + {2'b00, push} - {2'b00, consume}) < 3'd2;

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    drop_nxt     = drop;
    case (state)
      IDLE:    if (space_ok) state_nxt = REQ;
      REQ:     if (inst_addr_ok) state_nxt = WAIT;
      WAIT:    if (inst_data_ok) state_nxt = space_ok ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (data_in) begin
      drop_nxt = 1'b0;
      if (push) fetch_pc_nxt = fetch_pc + ADDR_WIDTH'(4);
    end
    if (redirect) begin
      fetch_pc_nxt = target;
      if (state != IDLE && !data_in) drop_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      drop     <= 1'b0;
      addr_q   <= '0;
      head     <= 1'b0;
      count    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        q_pc[i]   <= '0;
        q_inst[i] <= '0;
      end
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      drop     <= drop_nxt;
      if (state_nxt == REQ && state != REQ) addr_q <= fetch_pc_nxt;
      if (push) begin
        q_pc[tail]   <= fetch_pc;
        q_inst[tail] <= inst_rdata;
      end
      if (redirect) begin
        head  <= 1'b0;
        count <= 2'd0;
      end else begin
        head  <= head ^ pop;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && count == 2'd2))
    else $error("inst_fetch: push into full queue");

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: behavioural SRAM port plus a decode-side
// consumer comparing every delivered {pc, inst} against an expected-PC queue.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst;
  logic        branch_en, jump_en;
  logic [31:0] branch_addr, jump_addr;

  inst_fetch #(.ADDR_WIDTH(32), .INST_WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .branch_en(branch_en), .branch_addr(branch_addr),
    .jump_en(jump_en), .jump_addr(jump_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'h1357_9bdf;
  endfunction

  logic [31:0] sb_q[$];

  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          ready_all = 0;
  int          credits = 0;
  bit          mem_en = 1;
  bit          inject = 0;
  int          stall_left = 0;
  bit          acc_prev = 0;
  logic [31:0] acc_addr = '0;
  bit          redir_armed = 0;
  logic [31:0] redir_pc = '0, redir_baddr = '0, redir_jaddr = '0;
  bit          redir_br = 0, redir_jmp = 0;
  int          cons_cnt = 0, cons_cyc_prev = 0, cons_cyc_last = 0;

  // memory model and decode consumer, both driven on the falling edge
  initial begin
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = '0;
    out_ready = 0; branch_en = 0; jump_en = 0; branch_addr = '0; jump_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        inst_addr_ok = 0; inst_data_ok = 0; acc_prev = 0;
      end else begin
        if (inject) begin
          inst_data_ok = 1; inst_rdata = 32'hdead_beef;
        end else if (acc_prev) begin
          inst_data_ok = 1; inst_rdata = inst_of(acc_addr);
        end else begin
          inst_data_ok = 0;
        end
        inst_addr_ok = 0;
        if (inst_req && mem_en) begin
          if (stall_left > 0) stall_left--;
          else inst_addr_ok = 1;
        end
        acc_prev = inst_req && inst_addr_ok;
        acc_addr = inst_addr;
      end
      out_ready = ready_all || (credits > 0);
      branch_en = 0; jump_en = 0;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_out", out_pc, 32'hffff_ffff);
        end else begin
          logic [31:0] exp_pc;
          exp_pc = sb_q.pop_front();
          check_eq("out_pc", out_pc, exp_pc);
          check_eq("out_inst", out_inst, inst_of(exp_pc));
        end
        if (credits > 0) credits--;
        cons_cnt++;
        cons_cyc_prev = cons_cyc_last;
        cons_cyc_last = cyc;
        if (redir_armed && out_pc == redir_pc) begin
          branch_en = redir_br; jump_en = redir_jmp;
          branch_addr = redir_baddr; jump_addr = redir_jaddr;
          redir_armed = 0;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0;
    sb_q.delete();
    ready_all = 0; credits = 0; redir_armed = 0;
    mem_en = 1; inject = 0; stall_left = 0; cons_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_pc", out_pc, 0);
    check_eq("rst_out_inst", out_inst, 0);
    check_eq("rst_inst_req", inst_req, 0);
    check_eq("rst_inst_addr", inst_addr, 0);
  endtask

  task automatic wait_cons(input int n, input int budget);
    int k = 0;
    while (cons_cnt < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    ready_all = 0;
    check_eq("consumed", cons_cnt, n);
    check_eq("sb_left", sb_q.size(), 0);
  endtask

  initial begin
    // 1: streaming at full rate
    do_reset();
    sb_q.push_back(RESET_PC); sb_q.push_back(RESET_PC + 4); sb_q.push_back(RESET_PC + 8);
    ready_all = 1;
    rst_n = 1;
    @(posedge clk); #1;
    check_eq("t1_first_req", inst_req, 1);
    check_eq("t1_first_addr", inst_addr, RESET_PC);
    wait_cons(3, 40);
    check_eq("t1_gap", cons_cyc_last - cons_cyc_prev, 2);

    // 2: decode stalled, queue fills and fetch stops
    do_reset();
    for (int i = 0; i < 4; i++) sb_q.push_back(RESET_PC + 4 * i);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i >= 4) begin
        check_eq("t2_req_idle", inst_req, 0);
        check_eq("t2_valid", out_valid, 1);
        check_eq("t2_pc_hold", out_pc, RESET_PC);
        check_eq("t2_inst_hold", out_inst, inst_of(RESET_PC));
      end
    end
    ready_all = 1;
    wait_cons(4, 60);

    // 3: addr_ok withheld for 3 cycles
    do_reset();
    stall_left = 3;
    for (int i = 0; i < 3; i++) sb_q.push_back(RESET_PC + 4 * i);
    ready_all = 1;
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("t3_req_held", inst_req, 1);
      check_eq("t3_addr_held", inst_addr, RESET_PC);
    end
    wait_cons(3, 40);

    // 4: branch on head flushes the queued wrong-path entry
    do_reset();
    sb_q.push_back(RESET_PC); sb_q.push_back(RESET_PC + 4);
    sb_q.push_back(32'h1c00_0100); sb_q.push_back(32'h1c00_0104);
    rst_n = 1;
    repeat (8) @(posedge clk);
    #1 credits = 1;
    repeat (8) @(posedge clk);
    #1;
    check_eq("t4_head", out_pc, RESET_PC + 4);
    check_eq("t4_idle", inst_req, 0);
    redir_pc = RESET_PC + 4; redir_br = 1; redir_jmp = 0;
    redir_baddr = 32'h1c00_0100; redir_jaddr = 32'h1c00_0900;
    redir_armed = 1;
    ready_all = 1;
    wait_cons(4, 60);

    // 5: branch beats jump while a read is in flight; jump target alignment
    do_reset();
    sb_q.push_back(RESET_PC); sb_q.push_back(RESET_PC + 4);
    sb_q.push_back(32'h1c00_0200); sb_q.push_back(32'h1c00_0204);
    sb_q.push_back(32'h1c00_0100); sb_q.push_back(32'h1c00_0104);
    redir_pc = RESET_PC + 4; redir_br = 1; redir_jmp = 1;
    redir_baddr = 32'h1c00_0200; redir_jaddr = 32'h1c00_0300;
    redir_armed = 1;
    ready_all = 1;
    rst_n = 1;
    for (int k = 0; k < 40 && redir_armed; k++) begin
      @(posedge clk); #1;
    end
    check_eq("t5_fired", redir_armed, 0);
    redir_pc = 32'h1c00_0204; redir_br = 0; redir_jmp = 1;
    redir_baddr = 32'h1c00_0500; redir_jaddr = 32'h1c00_0103;
    redir_armed = 1;
    wait_cons(6, 80);

    // 6: reset during WAIT, stray data_ok right after release
    do_reset();
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("t6_in_wait", inst_req, 0);
    mem_en = 0;
    rst_n = 0;
    #1;
    check_eq("t6_rst_req", inst_req, 0);
    check_eq("t6_rst_addr", inst_addr, 0);
    repeat (2) @(posedge clk);
    #1;
    sb_q.push_back(RESET_PC); sb_q.push_back(RESET_PC + 4);
    cons_cnt = 0;
    rst_n = 1;
    inject = 1;
    @(posedge clk); #1;
    inject = 0;
    mem_en = 1;
    check_eq("t6_req", inst_req, 1);
    check_eq("t6_addr", inst_addr, RESET_PC);
    ready_all = 1;
    wait_cons(2, 40);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
